wb_retire_unit: RTL and testbench

//  Parametrised writeback/retire stage; sits after the MEM/WB register and drives the register-file write port and bypass.

---
 rtl/wb_retire_unit_if.sv | 35 +++
 rtl/wb_retire_unit.sv | 120 ++++++++++++
 tb/tb_wb_retire_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_unit_if.sv
// wb_retire_unit_if: MEM/WB slot, bridge read port and register-file write port bundle
interface wb_retire_unit_if #(
    parameter int XLEN = 32,
    parameter int RW = 5
);
    logic in_valid;
    logic in_ready;
    logic in_reg_write;
    logic in_mem_to_reg;
    logic in_is_byte;
    logic in_is_half;
    logic in_is_signed;
    logic in_addr_in_dm;
    logic [RW-1:0] in_rw;
    logic [XLEN-1:0] in_exout;
    logic [XLEN-1:0] in_dmout;
    logic br_req;
    logic [XLEN-1:0] br_addr;
    logic br_ack;
    logic [XLEN-1:0] br_rdata;
    logic wb_we;
    logic [RW-1:0] wb_rw;
    logic [XLEN-1:0] wb_wd;
    logic bus_err;
    modport master (
        output in_valid, in_reg_write, in_mem_to_reg, in_is_byte, in_is_half, in_is_signed,
        output in_addr_in_dm, in_rw, in_exout, in_dmout, br_ack, br_rdata,
        input in_ready, br_req, br_addr, wb_we, wb_rw, wb_wd, bus_err
    );
    modport slave (
        input in_valid, in_reg_write, in_mem_to_reg, in_is_byte, in_is_half, in_is_signed,
        input in_addr_in_dm, in_rw, in_exout, in_dmout, br_ack, br_rdata,
        output in_ready, br_req, br_addr, wb_we, wb_rw, wb_wd, bus_err
    );
endinterface

// File: rtl/wb_retire_unit.sv
// wb_retire_unit: writeback/retire stage with load extension and multi-cycle bridge loads (optional timeout: WB_BRIDGE_TIMEOUT_EN)
module wb_retire_unit #(
    parameter int XLEN = 32,
    parameter int RW = 5
`ifdef WB_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input logic clk,
    input logic rst,
    wb_retire_unit_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int LA = $clog2(NB);
    localparam int WW = XLEN > 32 ? 32 : XLEN;

    typedef enum logic {IDLE, WAIT_BR} state_t;

    state_t state, state_n;
    logic accept, br_load, ack, tmo;
    logic br_req, wb_we;
    logic [XLEN-1:0] br_addr, wb_wd;
    logic [RW-1:0] wb_rw, l_rw;
    logic l_we, l_byte, l_half, l_signed;

    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] d, input logic [LA-1:0] a,
                                            input logic b, input logic h, input logic s);
        int ai, wid;
        logic [XLEN-1:0] sh, m;
        ai = int'(a);
        wid = b ? 8 : h ? 16 : WW;
        sh = b ? d >> (8 * ai) : h ? d >> (8 * (ai & ~1)) : d >> (32 * (ai >> 2));
        m = ~({XLEN{1'b1}} << wid);
        return (sh & m) | ({XLEN{s & sh[wid-1]}} & ~m);
    endfunction

    assign bus.in_ready = state == IDLE;
    assign accept = bus.in_valid & bus.in_ready;
    assign br_load = bus.in_mem_to_reg & ~bus.in_addr_in_dm;
    assign ack = state == WAIT_BR && bus.br_ack;
    assign bus.br_req = br_req;
    assign bus.br_addr = br_addr;
    assign bus.wb_we = wb_we;
    assign bus.wb_rw = wb_rw;
    assign bus.wb_wd = wb_wd;

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic err;
    assign tmo = state == WAIT_BR && !bus.br_ack && cnt == CW'(TIMEOUT - 1);
    assign bus.bus_err = err;

    // Bridge wait counter, cleared on entry, and the one-cycle timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (accept && br_load) ? '0 : state == WAIT_BR ? cnt + CW'(1) : cnt;
            err <= tmo;
        end
    end
`else
    assign tmo = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // Next state: enter WAIT_BR on a bridge load, leave on ack or timeout
    always_comb begin
        state_n = (accept && br_load) ? WAIT_BR : (ack || tmo) ? IDLE : state;
    end

    // Retire register, bridge request and latched bridge-load context
    always_ff @(posedge clk) begin
        if (rst) begin
            br_req <= 1'b0;
            br_addr <= '0;
            wb_we <= 1'b0;
            wb_rw <= '0;
            wb_wd <= '0;
            l_rw <= '0;
            l_we <= 1'b0;
            l_byte <= 1'b0;
            l_half <= 1'b0;
            l_signed <= 1'b0;
        end else begin
            wb_we <= 1'b0;
            if (accept && br_load) begin
                br_req <= 1'b1;
                br_addr <= bus.in_exout;
                l_rw <= bus.in_rw;
                l_we <= bus.in_reg_write;
                l_byte <= bus.in_is_byte;
                l_half <= bus.in_is_half;
                l_signed <= bus.in_is_signed;
            end else if (accept) begin
                wb_we <= bus.in_reg_write & (bus.in_rw != '0);
                wb_rw <= bus.in_rw;
                wb_wd <= bus.in_mem_to_reg
                    ? ext(bus.in_dmout, bus.in_exout[LA-1:0], bus.in_is_byte, bus.in_is_half, bus.in_is_signed)
                    : bus.in_exout;
            end
            if (ack) begin
                br_req <= 1'b0;
                wb_we <= l_we & (l_rw != '0);
                wb_rw <= l_rw;
                wb_wd <= ext(bus.br_rdata, br_addr[LA-1:0], l_byte, l_half, l_signed);
            end
            if (tmo) br_req <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_retire_unit.sv
// tb_wb_retire_unit: directed and randomized checks of wb_retire_unit against a behavioural model
module tb_wb_retire_unit;
    localparam int XLEN = 32;
    localparam int RW = 5;
`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    int vectors = 0;
    int errors = 0;
    logic [RW-1:0] exp_rw;
    logic [XLEN-1:0] exp_wd;

    wb_retire_unit_if #(.XLEN(XLEN), .RW(RW)) bus ();
    wb_retire_unit #(.XLEN(XLEN), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_ext(input logic [31:0] d, input int unsigned addr,
                                              input bit b, input bit h, input bit s);
        int unsigned a = addr % 4;
        longint v;
        if (b) begin
            v = (d >> (8 * a)) & 255;
            if (s && v >= 128) v -= 256;
        end else if (h) begin
            v = (d >> (8 * (a - a % 2))) & 65535;
            if (s && v >= 32768) v -= 65536;
        end else begin
            v = d;
        end
        return v[31:0];
    endfunction

    task automatic outputs(input logic we, input logic err);
        checkb("wb_we", bus.wb_we, we);
        check("wb_rw", XLEN'(bus.wb_rw), XLEN'(exp_rw));
        check("wb_wd", bus.wb_wd, exp_wd);
        checkb("bus_err", bus.bus_err, err);
        checkb("br_req_idle", bus.br_req, 1'b0);
        checkb("in_ready_idle", bus.in_ready, 1'b1);
    endtask

    task automatic drive(input logic [RW-1:0] rw, input bit rwe, input bit m2r, input bit b, input bit h,
                         input bit s, input bit indm, input logic [31:0] exout, input logic [31:0] dmout);
        bus.in_valid = 1'b1;
        bus.in_rw = rw;
        bus.in_reg_write = rwe;
        bus.in_mem_to_reg = m2r;
        bus.in_is_byte = b;
        bus.in_is_half = h;
        bus.in_is_signed = s;
        bus.in_addr_in_dm = indm;
        bus.in_exout = exout;
        bus.in_dmout = dmout;
    endtask

    task automatic apply_op(input logic [RW-1:0] rw, input bit rwe, input bit m2r, input bit b, input bit h,
                            input bit s, input bit indm, input logic [31:0] exout, input logic [31:0] dmout,
                            input logic [31:0] rdata, input int delay);
        bit bridge = m2r && !indm;
        drive(rw, rwe, m2r, b, h, s, indm, exout, dmout);
        checkb("in_ready_accept", bus.in_ready, 1'b1);
        tick;
        bus.in_valid = 1'b0;
        if (bridge) begin
            for (int i = 0; i < delay; i++) begin
                checkb("br_req_wait", bus.br_req, 1'b1);
                check("br_addr", bus.br_addr, exout);
                checkb("in_ready_wait", bus.in_ready, 1'b0);
                checkb("wb_we_wait", bus.wb_we, 1'b0);
                drive(5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
                if (i == delay - 1) begin
                    bus.br_ack = 1'b1;
                    bus.br_rdata = rdata;
                end
                tick;
            end
            bus.br_ack = 1'b0;
            bus.in_valid = 1'b0;
        end
        exp_rw = rw;
        exp_wd = !m2r ? exout : model_ext(bridge ? rdata : dmout, exout, b, h, s);
        outputs(rwe && rw != '0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            bus.br_ack = 1'($urandom_range(0, 1));
            bus.br_rdata = $urandom;
            tick;
            outputs(1'b0, 1'b0);
        end
        bus.br_ack = 1'b0;
    endtask

    initial begin
        bus.br_ack = 1'b0;
        bus.br_rdata = '0;
        drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        exp_rw = '0;
        exp_wd = '0;
        checkb("rst_in_ready", bus.in_ready, 1'b1);
        checkb("rst_br_req", bus.br_req, 1'b0);
        check("rst_br_addr", bus.br_addr, '0);
        checkb("rst_wb_we", bus.wb_we, 1'b0);
        check("rst_wb_rw", XLEN'(bus.wb_rw), '0);
        check("rst_wb_wd", bus.wb_wd, '0);
        checkb("rst_bus_err", bus.bus_err, 1'b0);
        rst = 1'b0;

        apply_op(5'd3, 1, 0, 0, 0, 0, 1, 32'h11, $urandom, 0, 0);
        check("alu_first", bus.wb_wd, 32'h11);
        apply_op(5'd4, 1, 0, 0, 0, 0, 1, 32'h22, $urandom, 0, 0);
        check("alu_second", bus.wb_wd, 32'h22);
        idle(2);

        apply_op(5'd5, 1, 1, 1, 0, 1, 1, 32'h1003, 32'h80FF7F01, 0, 0);
        check("dm_sbyte", bus.wb_wd, 32'hFFFFFF80);
        apply_op(5'd6, 1, 1, 0, 1, 0, 1, 32'h1002, 32'h80FF7F01, 0, 0);
        check("dm_uhalf", bus.wb_wd, 32'h000080FF);
        apply_op(5'd6, 1, 1, 0, 1, 1, 1, 32'h1003, 32'h80FF7F01, 0, 0);
        check("dm_shalf_misaligned", bus.wb_wd, 32'hFFFF80FF);

        apply_op(5'd7, 1, 1, 0, 0, 0, 0, 32'h7F00, 0, 32'h12345678, 4);
        check("br_word", bus.wb_wd, 32'h12345678);
        apply_op(5'd8, 1, 0, 0, 0, 0, 1, 32'hCAFE, 0, 0, 0);
        apply_op(5'd10, 1, 1, 1, 0, 1, 0, 32'h7F01, 0, 32'h0000_8000, 1);
        check("br_sbyte_min_latency", bus.wb_wd, 32'hFFFFFF80);

        apply_op(5'd0, 1, 0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 0);
        checkb("rw0_no_write", bus.wb_we, 1'b0);
        idle(1);

        drive(5'd12, 1, 1, 0, 0, 0, 0, 32'h7F10, 0);
        tick;
        bus.in_valid = 1'b0;
        tick;
        checkb("pre_rst_br_req", bus.br_req, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_rw = '0;
        exp_wd = '0;
        checkb("midrst_br_req", bus.br_req, 1'b0);
        checkb("midrst_in_ready", bus.in_ready, 1'b1);
        checkb("midrst_wb_we", bus.wb_we, 1'b0);
        bus.br_ack = 1'b1;
        bus.br_rdata = 32'h5555AAAA;
        tick;
        bus.br_ack = 1'b0;
        outputs(1'b0, 1'b0);

`ifdef WB_BRIDGE_TIMEOUT_EN
        drive(5'd13, 1, 1, 0, 0, 0, 0, 32'h7F20, 0);
        tick;
        bus.in_valid = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            checkb("tmo_br_req", bus.br_req, 1'b1);
            checkb("tmo_no_err_yet", bus.bus_err, 1'b0);
            tick;
        end
        outputs(1'b0, 1'b1);
        idle(1);
        apply_op(5'd14, 1, 1, 0, 0, 0, 0, 32'h7F24, 0, 32'hA5A5F00F, TIMEOUT);
`else
        drive(5'd13, 1, 1, 0, 0, 0, 0, 32'h7F20, 0);
        tick;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checkb("hold_br_req", bus.br_req, 1'b1);
            checkb("hold_in_ready", bus.in_ready, 1'b0);
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_rw = '0;
        exp_wd = '0;
        outputs(1'b0, 1'b0);
`endif

        for (int n = 0; n < 150; n++) begin
            int kind = $urandom_range(0, 2);
            apply_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), kind != 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     kind != 2, $urandom, $urandom, $urandom, $urandom_range(1, 8));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
